regfile_alu: RTL and testbench
==============================

Name: regfile_alu

Overview:
- 16-entry x 16-bit register file fused with a single-cycle ALU: Rdest <= Rdest OP operand on a clock edge.
- Operand is register Rsrc or the 16-bit immediate, selected by Imm_s.
- Processor datapath core: combinational read of Rdest, registered write-back and flags.
- One clock; reset is synchronous and active-low; ports are Clk and Rst.

Parameters:
- DATA_W, 16, register and ALU width.
- NREGS, 16, register count; address width is 4.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous active-low reset.
- En  in  1  write/flag-update enable for this cycle.
- RdestRegLoc  in  4  destination register address; also first ALU operand.
- RsrcRegLoc  in  4  source register address; second operand when Imm_s=0.
- Imm  in  16  immediate operand.
- Imm_s  in  1  1 = operand B is Imm, 0 = operand B is reg[RsrcRegLoc].
- OpCode  in  5  ALU operation; only values 0..9 (plus 10 with option) are defined.
- RdestOut  out  16  combinational reg[RdestRegLoc].
- Flags  out  5  registered flags {C,L,F,Z,N}: bit4=C, bit3=L, bit2=F, bit1=Z, bit0=N.

Behaviour:
- Operand A = reg[RdestRegLoc]; B = Imm_s ? Imm : reg[RsrcRegLoc].
- Opcodes and results R:
  - ADD 0: A+B
  - SUB 1: A-B
  - CMP 2: A-B, flags only, no write
  - AND 3, OR 4, XOR 5: bitwise
  - NOT 6: ~B
  - LSH 7: A << B[3:0]
  - RSH 8: A >> B[3:0], logical
  - ARSH 9: A >>> B[3:0], sign-fill
- All arithmetic is modulo 2^16.
- Rising edge, Rst=0: all 16 registers <= 0; Flags <= 0. Reset overrides En.
- Rising edge, Rst=1, En=1, defined opcode other than CMP: reg[RdestRegLoc] <= R; Flags updated.
- CMP updates Flags only.
- En=0 or undefined opcode: no register or flag change.
- Latency: RdestOut reflects the write immediately after the edge, no extra cycle.
- Reads are combinational from current state; no same-cycle write bypass.
- Rsrc==Rdest is legal; both operands read pre-edge values.
- En held high over N edges applies the operation N times, e.g. accumulation.
- Flags:
  - ADD: C = carry out; F = signed overflow.
  - SUB/CMP: C = borrow (A<B unsigned); L = A<B unsigned; F = signed overflow; N = A<B signed.
  - Z = (R==0) for all ops; for CMP, Z = (A==B).
  - N = R[15] for all ops except SUB/CMP.
  - Logic and shift ops clear C, L, F.
  - ADD clears L.

Optional Feature:
- Macro: REGFILE_ALU_MUL_EN.
- Defined: OpCode 10 = MUL, R = low 16 bits of A*B, written like ADD; Z/N per R; C = 1 if the upper 16 product bits are nonzero; L, F cleared.
- Undefined: opcode 10 is undefined (no write, flags hold).

Decomposition:
- Shared package regfile_alu_pkg holds opcode localparams (ADD..ARSH, MUL), flag bit indices (FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0), and DATA_W.
- Natural sub-module: alu, purely combinational (A, B, OpCode -> R, next flags, write-valid).
- Top holds the register array, flag register, operand mux and write control.

Test Plan:
- Reset: Rst=0 for one edge after arbitrary writes -> every register reads 0, Flags=0.
- Immediate setup: Rdest=0, ADD, Imm_s=1, Imm=1, En=1 for one edge -> RdestOut=1; then for i=1..15, Rdest=i, Rsrc=0, Imm_s=0, ADD, one En edge -> RdestOut=1 each.
- Arithmetic flags:
  - r1=0x7FFF ADD Imm 1 -> 0x8000, F=1, N=1, C=0.
  - r2=0xFFFF ADD Imm 1 -> 0, C=1, Z=1.
- CMP: r3=5, Imm=7 -> r3 stays 5, L=1, N=1, Z=0, C=1; Imm=5 -> Z=1, L=0.
- Logic/shift:
  - r4=0x8001, ARSH Imm 1 -> 0xC000.
  - RSH Imm 1 -> 0x6000.
  - LSH Imm 4 -> 0x0000, Z=1.
  - NOT Imm 0x00FF -> 0xFF00.
- Enable/hold: En=0 with ADD pending -> register and Flags unchanged; undefined OpCode 31 with En=1 -> no change.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the regfile_alu datapath: widths, opcode encodings
// and flag bit positions. The optional MUL opcode is enabled by defining
// REGFILE_ALU_MUL_EN when building the design.
package regfile_alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 5;
    localparam int FLAG_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
    localparam logic [OP_W-1:0] OP_LSH  = 5'd7;
    localparam logic [OP_W-1:0] OP_RSH  = 5'd8;
    localparam logic [OP_W-1:0] OP_ARSH = 5'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd10;

    // Flag vector layout {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/regfile_alu_alu.sv
// Purely combinational ALU for regfile_alu. Produces the result, the next
// flag vector, and two qualifiers: write_valid (result goes to Rdest) and
// flag_valid (flags register takes flags_next). Undefined opcodes drive both
// qualifiers low so the caller holds all state.
// Opcode 10 (MUL) exists only when REGFILE_ALU_MUL_EN is defined.
module regfile_alu_alu
    import regfile_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags_next,
    output logic              write_valid,
    output logic              flag_valid
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [3:0]      sh;
    logic            signed_lt;
    logic            is_sub;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign sh        = b[3:0];
    assign signed_lt = $signed(a) < $signed(b);
    assign is_sub    = (op == OP_SUB) || (op == OP_CMP);

`ifdef REGFILE_ALU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    // Operation decode; C/L/F default to cleared so logic and shift ops need no extra code
    always_comb begin
        result      = '0;
        flags_next  = '0;
        write_valid = 1'b0;
        flag_valid  = 1'b0;
        case (op)
            OP_ADD: begin
                result             = sum[DATA_W-1:0];
                flags_next[FLAG_C] = sum[DATA_W];
                flags_next[FLAG_F] = (a[DATA_W-1] == b[DATA_W-1]) &&
                                     (sum[DATA_W-1] != a[DATA_W-1]);
                write_valid        = 1'b1;
                flag_valid         = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // diff[DATA_W] is the borrow, i.e. unsigned A<B
                result             = diff[DATA_W-1:0];
                flags_next[FLAG_C] = diff[DATA_W];
                flags_next[FLAG_L] = diff[DATA_W];
                flags_next[FLAG_F] = (a[DATA_W-1] != b[DATA_W-1]) &&
                                     (diff[DATA_W-1] != a[DATA_W-1]);
                write_valid        = (op == OP_SUB);
                flag_valid         = 1'b1;
            end
            OP_AND: begin
                result      = a & b;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_OR: begin
                result      = a | b;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_XOR: begin
                result      = a ^ b;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_NOT: begin
                result      = ~b;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_LSH: begin
                result      = a << sh;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_RSH: begin
                result      = a >> sh;
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
            OP_ARSH: begin
                result      = $unsigned($signed(a) >>> sh);
                write_valid = 1'b1;
                flag_valid  = 1'b1;
            end
`ifdef REGFILE_ALU_MUL_EN
            OP_MUL: begin
                result             = prod[DATA_W-1:0];
                flags_next[FLAG_C] = |prod[2*DATA_W-1:DATA_W];
                write_valid        = 1'b1;
                flag_valid         = 1'b1;
            end
`endif
            default: begin
                result      = '0;
                write_valid = 1'b0;
                flag_valid  = 1'b0;
            end
        endcase
        // Z and N are common to every defined op; SUB/CMP report signed A<B on N
        if (flag_valid) begin
            flags_next[FLAG_Z] = (result == '0);
            flags_next[FLAG_N] = is_sub ? signed_lt : result[DATA_W-1];
        end
    end

endmodule

// File: rtl/regfile_alu.sv
// regfile_alu top: 16 x 16-bit register file fused with a single-cycle ALU.
// Each enabled edge performs Rdest <= Rdest OP (Imm or Rsrc). RdestOut is a
// combinational read of the current register contents; Flags is registered.
// Define REGFILE_ALU_MUL_EN to add the MUL opcode (10).
module regfile_alu
    import regfile_alu_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [ADDR_W-1:0] RdestRegLoc,
    input  logic [ADDR_W-1:0] RsrcRegLoc,
    input  logic [DATA_W-1:0] Imm,
    input  logic              Imm_s,
    input  logic [OP_W-1:0]   OpCode,
    output logic [DATA_W-1:0] RdestOut,
    output logic [FLAG_W-1:0] Flags
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [FLAG_W-1:0] flags_reg;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic              alu_write_valid;
    logic              alu_flag_valid;

    // Both operands come from pre-edge state, so Rsrc==Rdest needs no special case
    assign operand_a = regs[RdestRegLoc];
    assign operand_b = Imm_s ? Imm : regs[RsrcRegLoc];
    assign RdestOut  = operand_a;
    assign Flags     = flags_reg;

    regfile_alu_alu u_alu (
        .a           (operand_a),
        .b           (operand_b),
        .op          (OpCode),
        .result      (alu_result),
        .flags_next  (alu_flags),
        .write_valid (alu_write_valid),
        .flag_valid  (alu_flag_valid)
    );

    // Register array write-back; reset clears every entry and overrides En
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (En && alu_write_valid) begin
            regs[RdestRegLoc] <= alu_result;
        end
    end

    // Flag register; CMP updates here even though it never writes the array
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            flags_reg <= '0;
        end else if (En && alu_flag_valid) begin
            flags_reg <= alu_flags;
        end
    end

endmodule

// File: tb/tb_regfile_alu.sv
// Self-checking bench for regfile_alu: directed vector table, randomized
// operations against a behavioural model, and reset checks.
module tb_regfile_alu;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic [3:0]  RdestRegLoc;
    logic [3:0]  RsrcRegLoc;
    logic [15:0] Imm;
    logic        Imm_s;
    logic [4:0]  OpCode;
    logic [15:0] RdestOut;
    logic [4:0]  Flags;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_regs [16];
    logic [4:0]  m_flags;

    regfile_alu dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .RdestRegLoc (RdestRegLoc),
        .RsrcRegLoc  (RsrcRegLoc),
        .Imm         (Imm),
        .Imm_s       (Imm_s),
        .OpCode      (OpCode),
        .RdestOut    (RdestOut),
        .Flags       (Flags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        en;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        imm_s;
        logic [4:0]  op;
        logic [15:0] exp_val;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic en, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [15:0] imm, input logic imm_s, input logic [4:0] op);
        @(negedge Clk);
        En = en; RdestRegLoc = rd; RsrcRegLoc = rs;
        Imm = imm; Imm_s = imm_s; OpCode = op;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0; En = 1'b1; OpCode = 5'd0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_flags = '0;
    endtask

    task automatic check_all_regs(input string name);
        @(negedge Clk);
        En = 1'b0;
        for (int i = 0; i < 16; i++) begin
            RdestRegLoc = 4'(i);
            #1;
            check(name, i, RdestOut, 16'(m_regs[i]));
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference behaviour from the opcode rules, using plain integer arithmetic
    task automatic model_step(input logic en, input logic [3:0] rd, input logic [3:0] rs,
                              input logic [15:0] imm, input logic imm_s, input logic [4:0] op);
        int a, b, sa, sb, res, s;
        logic c, l, f, n, wr, defined;
        a  = m_regs[rd];
        b  = imm_s ? int'(imm) : m_regs[rs];
        sa = to_signed(a);
        sb = to_signed(b);
        c = 0; l = 0; f = 0; n = 0; wr = 1; defined = 1; res = 0;
        case (int'(op))
            0: begin
                res = (a + b) & 'hFFFF;
                c = (a + b) > 65535;
                s = sa + sb;
                f = (s > 32767) || (s < -32768);
                n = res >= 32768;
            end
            1, 2: begin
                res = (a - b) & 'hFFFF;
                c = a < b;
                l = a < b;
                s = sa - sb;
                f = (s > 32767) || (s < -32768);
                n = sa < sb;
                wr = (op == 5'd1);
            end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (~b) & 'hFFFF;
            7: res = (a << (b % 16)) & 'hFFFF;
            8: res = a >> (b % 16);
            9: res = (sa >>> (b % 16)) & 'hFFFF;
`ifdef REGFILE_ALU_MUL_EN
            10: begin
                longint p;
                p = longint'(a) * longint'(b);
                res = int'(p & 'hFFFF);
                c = (p >> 16) != 0;
            end
`endif
            default: defined = 0;
        endcase
        if (op >= 5'd3 && op <= 5'd10) n = res >= 32768;
        if (en && defined) begin
            if (wr) m_regs[rd] = res;
            m_flags = {c, l, f, (res == 0), n};
        end
    endtask

    initial begin
        logic [15:0] corner [5];
        logic [15:0] imm_r;
        logic [4:0]  op_r;
        logic        en_r;
        logic [3:0]  rd_r, rs_r;
        logic        ims_r;
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
        corner[3] = 16'h8000; corner[4] = 16'hFFFF;

        Rst = 1'b0; En = 1'b0; RdestRegLoc = '0; RsrcRegLoc = '0;
        Imm = '0; Imm_s = 1'b0; OpCode = '0;

        // Reset state
        do_reset();
        check_all_regs("reset_reg");
        check("reset_flags", 0, 16'(Flags), 16'h0);

        // Immediate setup: r0=1, then ri = ri + r0 = 1
        apply(1'b1, 4'd0, 4'd0, 16'd1, 1'b1, 5'd0);
        check("setup", 0, RdestOut, 16'd1);
        for (int i = 1; i < 16; i++) begin
            apply(1'b1, 4'(i), 4'd0, 16'd0, 1'b0, 5'd0);
            check("setup", i, RdestOut, 16'd1);
        end

        // Directed vectors; every register starts at 1
        //            en  rd  rs  imm       ims op    value     {C,L,F,Z,N}
        vecs.push_back('{1, 1, 0, 16'h0000, 1, 3, 16'h0000, 5'b00010});
        vecs.push_back('{1, 1, 0, 16'h7FFF, 1, 4, 16'h7FFF, 5'b00000});
        vecs.push_back('{1, 1, 0, 16'h0001, 1, 0, 16'h8000, 5'b00101});
        vecs.push_back('{1, 2, 0, 16'h0000, 1, 3, 16'h0000, 5'b00010});
        vecs.push_back('{1, 2, 0, 16'hFFFF, 1, 4, 16'hFFFF, 5'b00001});
        vecs.push_back('{1, 2, 0, 16'h0001, 1, 0, 16'h0000, 5'b10010});
        vecs.push_back('{1, 3, 0, 16'h0000, 1, 3, 16'h0000, 5'b00010});
        vecs.push_back('{1, 3, 0, 16'h0005, 1, 4, 16'h0005, 5'b00000});
        vecs.push_back('{1, 3, 0, 16'h0007, 1, 2, 16'h0005, 5'b11001});
        vecs.push_back('{1, 3, 0, 16'h0005, 1, 2, 16'h0005, 5'b00010});
        vecs.push_back('{1, 4, 0, 16'h0000, 1, 3, 16'h0000, 5'b00010});
        vecs.push_back('{1, 4, 0, 16'h8001, 1, 4, 16'h8001, 5'b00001});
        vecs.push_back('{1, 4, 0, 16'h0001, 1, 9, 16'hC000, 5'b00001});
        vecs.push_back('{1, 4, 0, 16'h0001, 1, 8, 16'h6000, 5'b00000});
        vecs.push_back('{1, 4, 0, 16'h0004, 1, 7, 16'h0000, 5'b00010});
        vecs.push_back('{1, 4, 0, 16'h00FF, 1, 6, 16'hFF00, 5'b00001});
        vecs.push_back('{0, 4, 0, 16'h0001, 1, 0, 16'hFF00, 5'b00001});
        vecs.push_back('{1, 4, 0, 16'h0001, 1, 31, 16'hFF00, 5'b00001});
        vecs.push_back('{1, 5, 0, 16'h0002, 1, 1, 16'hFFFF, 5'b11001});
        vecs.push_back('{1, 5, 0, 16'hFFFF, 1, 5, 16'h0000, 5'b00010});
        vecs.push_back('{1, 6, 0, 16'h0003, 1, 0, 16'h0004, 5'b00000});
        vecs.push_back('{1, 6, 0, 16'h0003, 1, 0, 16'h0007, 5'b00000});
        vecs.push_back('{1, 6, 0, 16'h0003, 1, 0, 16'h000A, 5'b00000});
        vecs.push_back('{1, 7, 7, 16'h0000, 0, 0, 16'h0002, 5'b00000});
        vecs.push_back('{1, 7, 7, 16'h0000, 0, 0, 16'h0004, 5'b00000});
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].imm_s, vecs[i].op);
            check("vec_val", i, RdestOut, vecs[i].exp_val);
            check("vec_flags", i, 16'(Flags), 16'(vecs[i].exp_flags));
        end

        // Randomized operations against the model, starting from a clean reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en_r  = ($urandom_range(0, 7) != 0);
            rd_r  = 4'($urandom_range(0, 15));
            rs_r  = 4'($urandom_range(0, 15));
            ims_r = 1'($urandom_range(0, 1));
            op_r  = 5'($urandom_range(0, 11));
            if (op_r == 5'd11) op_r = 5'd31;
            imm_r = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            model_step(en_r, rd_r, rs_r, imm_r, ims_r, op_r);
            apply(en_r, rd_r, rs_r, imm_r, ims_r, op_r);
            check("rand_val", i, RdestOut, 16'(m_regs[rd_r]));
            check("rand_flags", i, 16'(Flags), 16'(m_flags));
        end
        check_all_regs("rand_final");

        // Reset after arbitrary contents clears everything
        do_reset();
        check_all_regs("reset2_reg");
        check("reset2_flags", 0, 16'(Flags), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
